// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types and constants for the audio playback sequencer
package audio_pkg;

  // Playback sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_LATCH = 2'd2,
    ST_WAIT  = 2'd3
  } play_state_e;

  // Default build: 2 s of 44.1 kHz audio, 12-bit samples, 12 MHz system clock
  localparam int unsigned DEF_ADDR_BITS       = 17;
  localparam int unsigned DEF_DATA_BITS       = 12;
  localparam int unsigned DEF_NUM_SAMPLES     = 88200;
  localparam int unsigned DEF_CLKS_PER_SAMPLE = 272;

  // Offset-binary zero level: the value the PWM sees when nothing is playing
  function automatic int unsigned midscale(input int unsigned data_bits);
    return 32'd1 << (data_bits - 1);
  endfunction

endpackage

// File: rtl/audio_playback_ctrl.sv
// rtl/audio_playback_ctrl.sv - steps a 1-cycle-latency sample LUT at the audio rate and holds each sample for the PWM
module audio_playback_ctrl
  import audio_pkg::*;
#(
  parameter int unsigned ADDR_BITS       = DEF_ADDR_BITS,
  parameter int unsigned DATA_BITS       = DEF_DATA_BITS,
  parameter int unsigned NUM_SAMPLES     = DEF_NUM_SAMPLES,
  parameter int unsigned CLKS_PER_SAMPLE = DEF_CLKS_PER_SAMPLE
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 start_in,
  input  logic                 stop_in,
  input  logic                 loop_in,
  output logic [ADDR_BITS-1:0] lut_addr_out,
  input  logic [DATA_BITS-1:0] lut_data_in,
  output logic [DATA_BITS-1:0] sample_out,
  output logic                 sample_valid_out,
  output logic                 busy_out,
  output logic                 done_out
);

  localparam int unsigned CNT_BITS = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
  localparam logic [CNT_BITS-1:0]  LAST_CNT  = CNT_BITS'(CLKS_PER_SAMPLE - 1);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NUM_SAMPLES - 1);
  localparam logic [DATA_BITS-1:0] MIDSCALE  = DATA_BITS'(midscale(DATA_BITS));

  play_state_e          state_q;
  logic [CNT_BITS-1:0]  cnt_q;
  logic [CNT_BITS-1:0]  cnt_d;
  logic [ADDR_BITS-1:0] addr_q;
  logic [ADDR_BITS-1:0] addr_d;
  logic [DATA_BITS-1:0] sample_q;
  logic                 valid_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 period_end;
  logic                 at_last_addr;

  // Period counter and address successor; the counter runs from READ entry so a
  // sample period is always exactly CLKS_PER_SAMPLE cycles including the wrap.
  always_comb begin
    cnt_d        = cnt_q + 1'b1;
    addr_d       = addr_q + 1'b1;
    period_end   = (cnt_q == LAST_CNT);
    at_last_addr = (addr_q == LAST_ADDR);
  end

  // Playback FSM; every output is a register so nothing leaks combinationally from the inputs
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      sample_q <= MIDSCALE;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      if (stop_in && (state_q != ST_IDLE)) begin
        // Abort: drop any sample in flight and park the PWM at the zero level
        state_q  <= ST_IDLE;
        cnt_q    <= '0;
        sample_q <= MIDSCALE;
        busy_q   <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (start_in && !stop_in) begin
              addr_q  <= '0;
              cnt_q   <= '0;
              state_q <= ST_READ;
              busy_q  <= 1'b1;
            end
          end
          ST_READ: begin
            // Address has been stable for a cycle; LUT captures on this edge
            cnt_q   <= cnt_d;
            state_q <= ST_LATCH;
          end
          ST_LATCH: begin
            sample_q <= lut_data_in;
            valid_q  <= 1'b1;
            cnt_q    <= cnt_d;
            state_q  <= ST_WAIT;
          end
          ST_WAIT: begin
            if (!period_end) begin
              cnt_q <= cnt_d;
            end else if (!at_last_addr) begin
              addr_q  <= addr_d;
              cnt_q   <= '0;
              state_q <= ST_READ;
            end else if (loop_in) begin
              addr_q  <= '0;
              cnt_q   <= '0;
              state_q <= ST_READ;
            end else begin
              done_q   <= 1'b1;
              sample_q <= MIDSCALE;
              cnt_q    <= '0;
              busy_q   <= 1'b0;
              state_q  <= ST_IDLE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign lut_addr_out     = addr_q;
  assign sample_out       = sample_q;
  assign sample_valid_out = valid_q;
  assign busy_out         = busy_q;
  assign done_out         = done_q;

endmodule

// File: tb/tb_audio_playback_ctrl.sv
// tb/tb_audio_playback_ctrl.sv - directed self-checking bench for audio_playback_ctrl
module tb_audio_playback_ctrl;

  localparam int ADDR_BITS = 2;
  localparam int DATA_BITS = 12;
  localparam int NUM_SAMPLES = 4;
  localparam int CLKS_PER_SAMPLE = 8;
  localparam int LOG_N = 64;

  logic                 clk_in = 1'b0;
  logic                 rst_n_in = 1'b0;
  logic                 start_in = 1'b0;
  logic                 stop_in = 1'b0;
  logic                 loop_in = 1'b0;
  logic [ADDR_BITS-1:0] lut_addr_out;
  logic [DATA_BITS-1:0] lut_data_in;
  logic [DATA_BITS-1:0] sample_out;
  logic                 sample_valid_out;
  logic                 busy_out;
  logic                 done_out;

  int n_checks = 0;
  int n_errors = 0;

  logic                 v_log [LOG_N];
  logic [DATA_BITS-1:0] s_log [LOG_N];
  logic                 d_log [LOG_N];
  logic                 b_log [LOG_N];
  logic [ADDR_BITS-1:0] a_log [LOG_N];

  logic [DATA_BITS-1:0] rom [NUM_SAMPLES] = '{12'h100, 12'h200, 12'h300, 12'h400};

  audio_playback_ctrl #(
    .ADDR_BITS      (ADDR_BITS),
    .DATA_BITS      (DATA_BITS),
    .NUM_SAMPLES    (NUM_SAMPLES),
    .CLKS_PER_SAMPLE(CLKS_PER_SAMPLE)
  ) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .start_in        (start_in),
    .stop_in         (stop_in),
    .loop_in         (loop_in),
    .lut_addr_out    (lut_addr_out),
    .lut_data_in     (lut_data_in),
    .sample_out      (sample_out),
    .sample_valid_out(sample_valid_out),
    .busy_out        (busy_out),
    .done_out        (done_out)
  );

  always #5 clk_in = ~clk_in;

  // Synchronous-read LUT model, one cycle of latency
  always @(posedge clk_in) lut_data_in <= rom[lut_addr_out];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Drives one playback run; rel cycle 0 carries the start pulse. Entered and left #1 after a posedge.
  task automatic run_play(input int n, input bit lp, input int stop_at, input int start2_at, input int rst_at);
    loop_in = lp;
    for (int r = 0; r < n; r++) begin
      start_in = (r == 0) || (r == start2_at);
      stop_in  = (r == stop_at);
      rst_n_in = !(r == rst_at);
      @(negedge clk_in);
      v_log[r] = sample_valid_out;
      s_log[r] = sample_out;
      d_log[r] = done_out;
      b_log[r] = busy_out;
      a_log[r] = lut_addr_out;
      @(posedge clk_in);
      #1;
    end
    start_in = 1'b0;
    stop_in  = 1'b0;
    rst_n_in = 1'b1;
    loop_in  = 1'b0;
  endtask

  // Valid pulses expected at 3, 11, 19, ... up to last_valid, cycling through the LUT
  task automatic verify(input string nm, input int n, input int last_valid, input int done_cyc);
    for (int r = 0; r < n; r++) begin
      bit ev;
      ev = (r >= 3) && (((r - 3) % 8) == 0) && (r <= last_valid);
      check_eq($sformatf("%s.valid@%0d", nm, r), 32'(v_log[r]), 32'(ev));
      if (ev)
        check_eq($sformatf("%s.data@%0d", nm, r), 32'(s_log[r]), 32'h100 * ((((r - 3) / 8) % 4) + 1));
      check_eq($sformatf("%s.done@%0d", nm, r), 32'(d_log[r]), 32'(r == done_cyc));
    end
  endtask

  initial begin
    // Reset held for two cycles
    rst_n_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    @(negedge clk_in);
    check_eq("rst.sample", 32'(sample_out), 32'h800);
    check_eq("rst.busy", 32'(busy_out), 32'h0);
    check_eq("rst.addr", 32'(lut_addr_out), 32'h0);
    check_eq("rst.valid", 32'(sample_valid_out), 32'h0);
    check_eq("rst.done", 32'(done_out), 32'h0);
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;

    // Single non-looped play
    run_play(40, 1'b0, -1, -1, -1);
    verify("single", 40, 27, 33);
    check_eq("single.addr@1", 32'(a_log[1]), 32'h0);
    check_eq("single.addr@9", 32'(a_log[9]), 32'h1);
    check_eq("single.addr@25", 32'(a_log[25]), 32'h3);
    check_eq("single.busy@1", 32'(b_log[1]), 32'h1);
    check_eq("single.busy@32", 32'(b_log[32]), 32'h1);
    check_eq("single.busy@34", 32'(b_log[34]), 32'h0);
    check_eq("single.sample@34", 32'(s_log[34]), 32'h800);

    // Looped play: seamless wrap back to 0x100 at cycle 35, stopped in cycle 43
    run_play(44, 1'b1, 43, -1, -1);
    verify("loop", 44, 43, -1);
    check_eq("loop.addr@33", 32'(a_log[33]), 32'h0);
    @(negedge clk_in);
    check_eq("loop.idle_busy", 32'(busy_out), 32'h0);
    check_eq("loop.idle_sample", 32'(sample_out), 32'h800);
    @(posedge clk_in);
    #1;

    // Stop in a WAIT cycle
    run_play(40, 1'b0, 13, -1, -1);
    verify("stop13", 40, 11, -1);
    check_eq("stop13.busy@13", 32'(b_log[13]), 32'h1);
    check_eq("stop13.busy@14", 32'(b_log[14]), 32'h0);
    check_eq("stop13.sample@14", 32'(s_log[14]), 32'h800);

    // Stop in the LATCH cycle of the second sample: 0x200 is never published
    run_play(24, 1'b0, 10, -1, -1);
    verify("stoplatch", 24, 3, -1);
    check_eq("stoplatch.sample@11", 32'(s_log[11]), 32'h800);
    check_eq("stoplatch.busy@11", 32'(b_log[11]), 32'h0);

    // start_in with stop_in in IDLE stays idle
    start_in = 1'b1;
    stop_in  = 1'b1;
    @(posedge clk_in);
    #1;
    start_in = 1'b0;
    stop_in  = 1'b0;
    @(negedge clk_in);
    check_eq("contend.busy", 32'(busy_out), 32'h0);
    check_eq("contend.valid", 32'(sample_valid_out), 32'h0);
    @(posedge clk_in);
    #1;

    // Second start while busy is ignored
    run_play(40, 1'b0, -1, 5, -1);
    verify("restart", 40, 27, 33);
    check_eq("restart.addr@9", 32'(a_log[9]), 32'h1);
    check_eq("restart.addr@17", 32'(a_log[17]), 32'h2);

    // Reset mid-play, then a fresh start replays from the top
    run_play(14, 1'b0, -1, -1, 12);
    verify("midrst", 13, 11, -1);
    check_eq("midrst.busy@13", 32'(b_log[13]), 32'h0);
    check_eq("midrst.sample@13", 32'(s_log[13]), 32'h800);
    check_eq("midrst.addr@13", 32'(a_log[13]), 32'h0);
    check_eq("midrst.valid@13", 32'(v_log[13]), 32'h0);
    check_eq("midrst.done@13", 32'(d_log[13]), 32'h0);
    run_play(12, 1'b0, -1, -1, -1);
    verify("replay", 12, 11, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
